// File: rtl/dot_product_engine_if.sv
// Handshake, operand-memory read and result-memory write bundle for dot_product_engine.
// The engine uses the slave modport; the job issuer and memory side use master.
interface dot_product_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = 5
);
    logic                  start;
    logic                  signed_mode;
    logic [ADDR_WIDTH-1:0] base_addr_a;
    logic [ADDR_WIDTH-1:0] base_addr_b;
    logic [LEN_WIDTH-1:0]  vec_len;
    logic [ADDR_WIDTH-1:0] result_addr;
    logic                  rd_en_a;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic                  rd_en_b;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport slave (
        input  start, signed_mode, base_addr_a, base_addr_b, vec_len, result_addr,
        input  rd_data_a, rd_data_b,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output wr_en, wr_addr, wr_data, busy, done, result
    );

    modport master (
        output start, signed_mode, base_addr_a, base_addr_b, vec_len, result_addr,
        output rd_data_a, rd_data_b,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  wr_en, wr_addr, wr_data, busy, done, result
    );
endinterface

// File: rtl/dot_product_engine.sv
// Reads two operand vectors word by word, multiply-accumulates LANES element pairs per word
// and writes one sign- or zero-extended result word to the output memory.
//
// state   | meaning
// IDLE    | waiting for start; job parameters captured on acceptance
// READ    | one read per cycle from both operand memories
// DRAIN   | no reads; last returned word is accumulated
// WRITE   | single result write strobe
// DONE    | single-cycle completion pulse
module dot_product_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ELEM_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = 5,
    parameter int ACC_WIDTH  = 24
) (
    input logic clk,
    input logic rst,
    dot_product_engine_if.slave bus
);
    localparam int LANES = DATA_WIDTH / ELEM_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] base_a_q;
    logic [ADDR_WIDTH-1:0] base_b_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [ADDR_WIDTH-1:0] res_addr_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  valid_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [ACC_WIDTH-1:0]  acc_d;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_a_q;
    logic [ADDR_WIDTH-1:0] rd_addr_b_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] result_q;

    logic [ACC_WIDTH-1:0]  lane_sum;
    logic [ACC_WIDTH-1:0]  a_ext;
    logic [ACC_WIDTH-1:0]  b_ext;
    logic [DATA_WIDTH-1:0] acc_ext;

    // Operands are extended to ACC_WIDTH first; the truncated product is then exact modulo 2^ACC_WIDTH.
    always_comb begin
        lane_sum = '0;
        a_ext    = '0;
        b_ext    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mode_q) begin
                a_ext = ACC_WIDTH'($signed(bus.rd_data_a[i*ELEM_WIDTH +: ELEM_WIDTH]));
                b_ext = ACC_WIDTH'($signed(bus.rd_data_b[i*ELEM_WIDTH +: ELEM_WIDTH]));
            end else begin
                a_ext = ACC_WIDTH'(bus.rd_data_a[i*ELEM_WIDTH +: ELEM_WIDTH]);
                b_ext = ACC_WIDTH'(bus.rd_data_b[i*ELEM_WIDTH +: ELEM_WIDTH]);
            end
            lane_sum = lane_sum + a_ext * b_ext;
        end
        acc_d   = valid_q ? acc_q + lane_sum : acc_q;
        acc_ext = mode_q ? DATA_WIDTH'($signed(acc_d)) : DATA_WIDTH'(acc_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            len_q       <= '0;
            res_addr_q  <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            acc_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            valid_q <= rd_en_q;
            acc_q   <= acc_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q     <= bus.signed_mode;
                        base_a_q   <= bus.base_addr_a;
                        base_b_q   <= bus.base_addr_b;
                        len_q      <= bus.vec_len;
                        res_addr_q <= bus.result_addr;
                        acc_q      <= '0;
                        busy_q     <= 1'b1;
                        if (bus.vec_len == '0) begin
                            cnt_q     <= '0;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= bus.result_addr;
                            wr_data_q <= '0;
                            result_q  <= '0;
                            state_q   <= S_WRITE;
                        end else begin
                            // Word 0 is issued in the first READ cycle; cnt_q counts words issued.
                            cnt_q       <= LEN_WIDTH'(1);
                            rd_en_q     <= 1'b1;
                            rd_addr_a_q <= bus.base_addr_a;
                            rd_addr_b_q <= bus.base_addr_b;
                            state_q     <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (cnt_q == len_q) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        rd_addr_a_q <= base_a_q + ADDR_WIDTH'(cnt_q);
                        rd_addr_b_q <= base_b_q + ADDR_WIDTH'(cnt_q);
                        cnt_q       <= cnt_q + LEN_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= res_addr_q;
                    wr_data_q <= acc_ext;
                    result_q  <= acc_ext;
                    state_q   <= S_WRITE;
                end
                S_WRITE: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_en_a   = rd_en_q;
    assign bus.rd_en_b   = rd_en_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
endmodule
